// File: rtl/uart_rxfifo_rcv.sv
// rtl/uart_rxfifo_rcv.sv - UART receiver (8N1) feeding a first-word-fall-through receive FIFO
// Defining UART_RX_PARITY_EN switches the frame to 8E1 and enables PARITY_ERR.
module uart_rxfifo_rcv #(
   parameter int CLKS_PER_BIT = 434,
   parameter int AW           = 5
) (
   input  logic        SCLK,
   input  logic        RST_n,
   input  logic        RXD,
   input  logic        FIFO_RDEN,
   output logic [7:0]  FIFO_RD_DATA,
   output logic        FIFO_Empty,
   output logic        FIFO_FULL,
   output logic [AW:0] FIFO_COUNT,
   input  logic        ERR_CLR,
   output logic        FRAME_ERR,
   output logic        OVERRUN,
   output logic        PARITY_ERR
);
   localparam int DEPTH = 2**AW;
   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam logic [TW-1:0] T_HALF   = TW'(CLKS_PER_BIT/2 - 1);
   localparam logic [TW-1:0] T_FULL   = TW'(CLKS_PER_BIT - 1);
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};
   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};

`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PAR, S_STOP, S_BRK} state_t;
`else
   typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_STOP, S_BRK} state_t;
`endif

   state_t        state;
   logic          rxd_m, rxd_s;
   logic [TW-1:0] timer;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic          sample;
   logic          par_bad;
   logic          push;
   logic          pop;
   logic          push_ok;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;

   assign sample = (timer == '0);
   assign push   = (state == S_STOP) && sample && rxd_s && !par_bad;

`ifndef UART_RX_PARITY_EN
   assign par_bad    = 1'b0;
   assign PARITY_ERR = 1'b0;
`endif

   // Line side: synchroniser, bit timer and frame FSM
   always_ff @(posedge SCLK or negedge RST_n) begin
      if (!RST_n) begin
         rxd_m     <= 1'b1;
         rxd_s     <= 1'b1;
         state     <= S_IDLE;
         timer     <= '0;
         bit_idx   <= '0;
         shreg     <= '0;
         FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_bad    <= 1'b0;
         PARITY_ERR <= 1'b0;
`endif
      end else begin
         rxd_m <= RXD;
         rxd_s <= rxd_m;
         if (ERR_CLR) begin
            FRAME_ERR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            PARITY_ERR <= 1'b0;
`endif
         end
         case (state)
            S_IDLE: begin
               if (!rxd_s) begin
                  state <= S_START;
                  timer <= T_HALF;
               end
            end
            S_START: begin
               if (!sample) begin
                  timer <= timer - TW'(1);
               end else if (!rxd_s) begin
                  state   <= S_DATA;
                  bit_idx <= '0;
                  timer   <= T_FULL;
`ifdef UART_RX_PARITY_EN
                  par_bad <= 1'b0;
`endif
               end else begin
                  state <= S_IDLE;
               end
            end
            S_DATA: begin
               if (!sample) begin
                  timer <= timer - TW'(1);
               end else begin
                  shreg   <= {rxd_s, shreg[7:1]};
                  timer   <= T_FULL;
                  bit_idx <= bit_idx + 3'd1;
                  if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                     state <= S_PAR;
`else
                     state <= S_STOP;
`endif
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            S_PAR: begin
               if (!sample) begin
                  timer <= timer - TW'(1);
               end else begin
                  timer <= T_FULL;
                  state <= S_STOP;
                  if (rxd_s != ^shreg) begin
                     par_bad    <= 1'b1;
                     PARITY_ERR <= 1'b1;
                  end
               end
            end
`endif
            S_STOP: begin
               if (!sample) begin
                  timer <= timer - TW'(1);
               end else if (rxd_s) begin
                  state <= S_IDLE;
               end else begin
                  FRAME_ERR <= 1'b1;
                  state     <= S_BRK;
               end
            end
            S_BRK: begin
               if (rxd_s) state <= S_IDLE;
            end
            default: state <= S_IDLE;
         endcase
      end
   end

   assign FIFO_Empty   = (FIFO_COUNT == '0);
   assign FIFO_FULL    = (FIFO_COUNT == CNT_FULL);
   assign pop          = FIFO_RDEN && !FIFO_Empty;
   assign push_ok      = push && (!FIFO_FULL || pop);
   assign FIFO_RD_DATA = mem[rd_ptr];

   always_ff @(posedge SCLK) begin
      if (push_ok) mem[wr_ptr] <= shreg;
   end

   // A pop on a full FIFO frees the slot the simultaneous push needs
   always_ff @(posedge SCLK or negedge RST_n) begin
      if (!RST_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         FIFO_COUNT <= '0;
         OVERRUN    <= 1'b0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)     rd_ptr <= rd_ptr + PTR_ONE;
         case ({push_ok, pop})
            2'b10:   FIFO_COUNT <= FIFO_COUNT + CNT_ONE;
            2'b01:   FIFO_COUNT <= FIFO_COUNT - CNT_ONE;
            default: FIFO_COUNT <= FIFO_COUNT;
         endcase
         if (ERR_CLR)            OVERRUN <= 1'b0;
         if (push && !push_ok)   OVERRUN <= 1'b1;
      end
   end
endmodule

// File: tb/tb_uart_rxfifo_rcv.sv
// tb/tb_uart_rxfifo_rcv.sv - randomized self-checking bench for uart_rxfifo_rcv against a queue model
`timescale 1ns/1ps
module tb_uart_rxfifo_rcv;
   localparam int CPB   = 16;
   localparam int AW    = 5;
   localparam int DEPTH = 32;
`ifdef UART_RX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   // sync (2) + idle detect (1) + half bit, then whole bits to the centre of the last one
   localparam int PAR_OFF  = 3 + CPB/2 + 9*CPB;
   localparam int STOP_OFF = 3 + CPB/2 + (NBITS-1)*CPB;

   logic        SCLK = 1'b0;
   logic        RST_n, RXD, FIFO_RDEN, ERR_CLR;
   logic [7:0]  FIFO_RD_DATA;
   logic        FIFO_Empty, FIFO_FULL;
   logic [AW:0] FIFO_COUNT;
   logic        FRAME_ERR, OVERRUN, PARITY_ERR;

   uart_rxfifo_rcv #(.CLKS_PER_BIT(CPB), .AW(AW)) dut (
      .SCLK(SCLK), .RST_n(RST_n), .RXD(RXD), .FIFO_RDEN(FIFO_RDEN),
      .FIFO_RD_DATA(FIFO_RD_DATA), .FIFO_Empty(FIFO_Empty), .FIFO_FULL(FIFO_FULL),
      .FIFO_COUNT(FIFO_COUNT), .ERR_CLR(ERR_CLR), .FRAME_ERR(FRAME_ERR),
      .OVERRUN(OVERRUN), .PARITY_ERR(PARITY_ERR)
   );

   always #5 SCLK = ~SCLK;

   typedef struct { int cyc; int kind; logic [7:0] data; } ev_t;
   ev_t        evq[$];
   logic [7:0] mq[$];
   logic [7:0] got[$];
   bit         m_ferr, m_ovr, m_perr;
   int         cyc = 0;
   int         checks = 0, errors = 0;
   bit         chk_en = 0;
   bit         rand_done;
   int         lat;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h cycle=%0d", nm, act, exp, cyc);
      end
   endtask

   // Reference: byte queue plus sticky flags; frame outcomes land at scheduled cycles
   always @(posedge SCLK) begin : model
      ev_t        e;
      bit         pop_ok, push_req;
      logic [7:0] pd;
      cyc++;
      if (!RST_n) begin
         mq.delete(); evq.delete();
         m_ferr = 0; m_ovr = 0; m_perr = 0;
      end else begin
         push_req = 0;
         pd       = '0;
         pop_ok   = FIFO_RDEN && (mq.size() > 0);
         if (ERR_CLR) begin m_ferr = 0; m_ovr = 0; m_perr = 0; end
         while (evq.size() > 0 && evq[0].cyc == cyc) begin
            e = evq.pop_front();
            case (e.kind)
               0:       begin push_req = 1; pd = e.data; end
               1:       m_ferr = 1;
               default: m_perr = 1;
            endcase
         end
         if (pop_ok) void'(mq.pop_front());
         if (push_req) begin
            if (mq.size() < DEPTH) mq.push_back(pd);
            else                   m_ovr = 1;
         end
      end
   end

   always @(negedge SCLK) begin
      if (RST_n && chk_en) begin
         chk("count", FIFO_COUNT, mq.size());
         chk("empty", FIFO_Empty, mq.size() == 0);
         chk("full", FIFO_FULL, mq.size() == DEPTH);
         if (mq.size() > 0) chk("rd_data", FIFO_RD_DATA, mq[0]);
         chk("frame_err", FRAME_ERR, m_ferr);
         chk("overrun", OVERRUN, m_ovr);
         chk("parity_err", PARITY_ERR, m_perr);
      end
   end

   task automatic tick();
      @(posedge SCLK); #1;
   endtask

   task automatic send_frame(input logic [7:0] d, input bit stop_v, input bit par_flip,
                             input int pop_at, input int hold_bits, input bit leave_low);
      logic [NBITS-1:0] fr;
      int s, n;
      bit par_bad;
      s       = cyc;
      par_bad = (NBITS == 11) && par_flip;
      fr      = '0;
      fr[8:1] = d;
      if (NBITS == 11) fr[9] = (^d) ^ par_flip;
      fr[NBITS-1] = stop_v;
      if (par_bad) evq.push_back('{s + PAR_OFF, 2, d});
      if (!stop_v)       evq.push_back('{s + STOP_OFF, 1, d});
      else if (!par_bad) evq.push_back('{s + STOP_OFF, 0, d});
      n = (NBITS + hold_bits) * CPB;
      for (int i = 0; i < n; i++) begin
         RXD = (i < NBITS*CPB) ? fr[i/CPB] : 1'b0;
         if (pop_at >= 0) FIFO_RDEN = (i == pop_at);
         tick();
      end
      if (!leave_low) RXD = 1'b1;
      if (pop_at >= 0) FIFO_RDEN = 1'b0;
      repeat (8) tick();
   endtask

   task automatic drain();
      int k;
      got.delete();
      k = 0;
      while (FIFO_Empty !== 1'b1 && k < 80) begin
         got.push_back(FIFO_RD_DATA);
         FIFO_RDEN = 1'b1;
         tick();
         k++;
      end
      FIFO_RDEN = 1'b0;
      tick();
      chk("drain_empty", FIFO_Empty, 1);
   endtask

   task automatic pulse_clr();
      ERR_CLR = 1'b1; tick(); ERR_CLR = 1'b0; tick();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog cycle=%0d", cyc);
      $fatal(1);
   end

   initial begin
      RST_n = 0; RXD = 1; FIFO_RDEN = 0; ERR_CLR = 0;
      repeat (3) tick();
      chk("rst_count", FIFO_COUNT, 0);
      chk("rst_empty", FIFO_Empty, 1);
      chk("rst_full", FIFO_FULL, 0);
      chk("rst_flags", {FRAME_ERR, OVERRUN, PARITY_ERR}, 3'b000);
      RST_n = 1; chk_en = 1;
      tick();

      // single byte, push latency and one pop
      lat = -1;
      fork
         send_frame(8'hA5, 1, 0, -1, 0, 0);
         begin
            int s0;
            s0 = cyc;
            for (int k = 0; k < 400; k++) begin
               @(negedge SCLK);
               if (FIFO_Empty === 1'b0) begin lat = cyc - s0; break; end
            end
         end
      join
      chk("t1_latency", lat, STOP_OFF);
      chk("t1_data", FIFO_RD_DATA, 8'hA5);
      chk("t1_count", FIFO_COUNT, 1);
      FIFO_RDEN = 1; tick(); FIFO_RDEN = 0; tick();
      chk("t1_popped", {FIFO_Empty, FIFO_COUNT}, {1'b1, 6'd0});

      // start-bit glitch
      RXD = 0; repeat (4) tick(); RXD = 1; repeat (30) tick();
      chk("t2_noflag", {FRAME_ERR, FIFO_COUNT}, 7'd0);

      // break: one frame error, clear while still low, then a clean byte
      send_frame(8'h3C, 0, 0, -1, 20, 1);
      chk("t3_ferr", FRAME_ERR, 1);
      pulse_clr();
      repeat (20*CPB) tick();
      chk("t3_once", FRAME_ERR, 0);
      RXD = 1; repeat (10) tick();
      pulse_clr();
      send_frame(8'h11, 1, 0, -1, 0, 0);
      chk("t3_next", FIFO_RD_DATA, 8'h11);
      drain();

      // fill past full, overrun, drain in order across pointer wrap
      for (int i = 0; i < 33; i++) begin
         send_frame(8'(i), 1, 0, -1, 0, 0);
         if (i == 31) chk("t4_full", FIFO_FULL, 1);
      end
      chk("t4_ovr", OVERRUN, 1);
      chk("t4_cnt", FIFO_COUNT, 32);
      drain();
      chk("t4_size", got.size(), 32);
      for (int k = 0; k < got.size(); k++) chk("t4_order", got[k], k);

      // push into full FIFO with a simultaneous pop
      pulse_clr();
      for (int i = 0; i < 32; i++) send_frame(8'(8'h40 + i), 1, 0, -1, 0, 0);
      send_frame(8'h77, 1, 0, STOP_OFF - 1, 0, 0);
      chk("t5_cnt", FIFO_COUNT, 32);
      chk("t5_ovr", OVERRUN, 0);
      drain();
      chk("t5_size", got.size(), 32);
      if (got.size() == 32) begin
         chk("t5_first", got[0], 8'h41);
         chk("t5_last", got[31], 8'h77);
      end

`ifdef UART_RX_PARITY_EN
      send_frame(8'h01, 1, 1, -1, 0, 0);
      chk("t6_perr", PARITY_ERR, 1);
      chk("t6_empty", FIFO_Empty, 1);
      send_frame(8'h01, 1, 0, -1, 0, 0);
      chk("t6_push", FIFO_RD_DATA, 8'h01);
      drain();
      pulse_clr();
`endif

      // random bytes, random errors, random reader and clears
      rand_done = 0;
      fork
         begin
            for (int f = 0; f < 24; f++) begin
               send_frame(8'($urandom), ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0), -1, 0, 0);
               repeat ($urandom_range(0, 12)) tick();
            end
            rand_done = 1;
         end
         begin
            while (!rand_done) begin
               FIFO_RDEN = ($urandom_range(0, 199) == 0);
               ERR_CLR   = ($urandom_range(0, 299) == 0);
               tick();
            end
            FIFO_RDEN = 0; ERR_CLR = 0;
         end
      join
      drain();

      // async reset mid-frame after a frame error and stored bytes
      send_frame(8'h21, 1, 0, -1, 0, 0);
      send_frame(8'h22, 0, 0, -1, 0, 0);
      RXD = 0; repeat (60) tick();
      RST_n = 0; repeat (3) tick();
      RXD = 1; RST_n = 1; repeat (20) tick();
      chk("t8_cnt", FIFO_COUNT, 0);
      chk("t8_flags", {FRAME_ERR, OVERRUN, PARITY_ERR}, 3'b000);
      send_frame(8'h5A, 1, 0, -1, 0, 0);
      chk("t8_data", FIFO_RD_DATA, 8'h5A);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
